int_to_int_wb_collector: RTL

//  Writeback collector on the output side of int_to_int_array. Captures each valid result beat
//  (dr_inttoint_d_out + cru_inttoint_out echo + smc_id), pairs 16-bit-destination low/high beats

---
 rtl/int_to_int_wb_collector.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/int_to_int_wb_collector.sv
// ============================================================================
// Module: int_to_int_wb_collector
//
// Purpose:
//   Writeback collector on the output side of int_to_int_array. The array
//   streams result beats without stalling. This block captures every valid
//   beat and pairs low/high halves of 16-bit-destination results into one
//   full 128-bit word. It queues the finished words in a small FIFO that
//   drains through a valid/ready register-file write port.
//
// Optional feature (compile-time macro):
//   INTTOINT_WB_TIMEOUT_EN - when defined, a low-half partial that waits
//   HOLD_TIMEOUT idle cycles for its high half is flushed on its own with
//   mask 8'h55. When the macro is undefined, a partial leaves the hold
//   register only when another beat arrives or on reset.
//
// Parameters:
//   FIFO_DEPTH    - writeback queue entries (power of 2, >= 2)
//   HOLD_TIMEOUT  - idle cycles a partial may wait (timeout build only)
//
// Ports:
//   clk                in   1    system clock
//   rst                in   1    synchronous reset, active-high
//   dr_inttoint_d_out  in   128  converter result, lane0=[127:96]..lane3=[31:0]
//   cru_inttoint_out   in   7    echoed uop; bit6=vld, bit4=dst_prec, bit0=dst_pos
//   smc_id_in          in   5    tag of the current beat
//   wb_vld             out  1    queue head valid
//   wb_rdy             in   1    write port accepts the head entry
//   wb_data            out  128  head write data (zero when queue empty)
//   wb_mask            out  8    bit k enables wb_data[16k+15:16k]
//   wb_id              out  5    head tag
//   err_overflow       out  1    sticky: a word was dropped for lack of space
// ============================================================================
module int_to_int_wb_collector #(
    parameter int FIFO_DEPTH   = 4,
    parameter int HOLD_TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] dr_inttoint_d_out,
    input  logic [6:0]   cru_inttoint_out,
    input  logic [4:0]   smc_id_in,
    output logic         wb_vld,
    input  logic         wb_rdy,
    output logic [127:0] wb_data,
    output logic [7:0]   wb_mask,
    output logic [4:0]   wb_id,
    output logic         err_overflow
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [7:0] MASK_FULL = 8'hFF;
    localparam logic [7:0] MASK_HI   = 8'hAA;
    localparam logic [7:0] MASK_LO   = 8'h55;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    typedef struct packed {
        logic [127:0] data;
        logic [7:0]   mask;
        logic [4:0]   id;
    } entry_t;

    state_t       state_q;
    state_t       state_d;

    logic [127:0] hold_data;
    logic [4:0]   hold_id;

    entry_t       mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] free;

    logic         beat;
    logic         is_full;
    logic         is_lo;
    logic         is_hi;
    logic         id_match;
    logic [127:0] merged;

    logic         pop;
    logic         push0_vld;
    logic         push1_vld;
    entry_t       push0_e;
    entry_t       push1_e;
    logic         acc0;
    logic         acc1;
    logic [1:0]   n_push;
    logic         do_latch;
    logic         timeout_fire;

    entry_t       head;

    // Only the valid, destination-precision and destination-position bits
    // steer the collector; the remaining echoed uop fields are don't-care.
    logic unused_cru_bits;
    assign unused_cru_bits = ^{cru_inttoint_out[5], cru_inttoint_out[3:1]};

    // Beat classification.
    assign beat     = cru_inttoint_out[6];
    assign is_full  = beat &&  cru_inttoint_out[4];
    assign is_lo    = beat && !cru_inttoint_out[4] && !cru_inttoint_out[0];
    assign is_hi    = beat && !cru_inttoint_out[4] &&  cru_inttoint_out[0];
    assign id_match = (smc_id_in == hold_id);

    // Pair merge: even halfwords come from the held low beat and odd
    // halfwords come from the arriving high beat.
    always_comb begin
        merged = '0;
        for (int k = 0; k < 8; k++) begin
            if ((k % 2) == 0) begin
                merged[16*k +: 16] = hold_data[16*k +: 16];
            end else begin
                merged[16*k +: 16] = dr_inttoint_d_out[16*k +: 16];
            end
        end
    end

    // Free slots are counted after this cycle's pop, so a full queue that is
    // being drained can still accept one new word.
    assign pop  = wb_vld && wb_rdy;
    assign free = CW'(FIFO_DEPTH) - count + CW'(pop);

`ifdef INTTOINT_WB_TIMEOUT_EN
    localparam int TW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT + 1) : 1;

    logic [TW-1:0] hold_cnt;

    // The counter restarts whenever a low half is latched. It saturates at
    // the last idle cycle so that a flush blocked by a full queue is retried
    // every following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (do_latch) begin
            hold_cnt <= '0;
        end else if (state_q == HOLD && !beat &&
                     hold_cnt != TW'(HOLD_TIMEOUT - 1)) begin
            hold_cnt <= hold_cnt + TW'(1);
        end
    end

    assign timeout_fire = (state_q == HOLD) && !beat &&
                          (hold_cnt == TW'(HOLD_TIMEOUT - 1)) && (free != '0);
`else
    assign timeout_fire = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. A low beat always leads to HOLD. Any other beat
    // in HOLD resolves the partial and returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (is_lo) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (beat) begin
                    state_d = is_lo ? HOLD : IDLE;
                end else if (timeout_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: up to two push requests per cycle. A displaced partial is
    // always request 0, so it is never overtaken by the beat that flushed it.
    always_comb begin
        push0_vld = 1'b0;
        push1_vld = 1'b0;
        push0_e   = '0;
        push1_e   = '0;
        do_latch  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (is_full) begin
                    push0_vld = 1'b1;
                    push0_e   = '{data: dr_inttoint_d_out, mask: MASK_FULL, id: smc_id_in};
                end else if (is_hi) begin
                    push0_vld = 1'b1;
                    push0_e   = '{data: dr_inttoint_d_out, mask: MASK_HI, id: smc_id_in};
                end else if (is_lo) begin
                    do_latch  = 1'b1;
                end
            end
            HOLD: begin
                if (is_hi && id_match) begin
                    push0_vld = 1'b1;
                    push0_e   = '{data: merged, mask: MASK_FULL, id: hold_id};
                end else if (beat) begin
                    push0_vld = 1'b1;
                    push0_e   = '{data: hold_data, mask: MASK_LO, id: hold_id};
                    if (is_full) begin
                        push1_vld = 1'b1;
                        push1_e   = '{data: dr_inttoint_d_out, mask: MASK_FULL, id: smc_id_in};
                    end else if (is_hi) begin
                        push1_vld = 1'b1;
                        push1_e   = '{data: dr_inttoint_d_out, mask: MASK_HI, id: smc_id_in};
                    end else begin
                        do_latch  = 1'b1;
                    end
                end else if (timeout_fire) begin
                    push0_vld = 1'b1;
                    push0_e   = '{data: hold_data, mask: MASK_LO, id: hold_id};
                end
            end
            default: begin
                push0_vld = 1'b0;
            end
        endcase
    end

    // Space arbitration: the earlier request takes the first free slot, and
    // any request without room is dropped and flagged.
    assign acc0   = push0_vld && (free != '0);
    assign acc1   = push1_vld && (free >= CW'(2));
    assign n_push = {1'b0, acc0} + {1'b0, acc1};

    // Hold register for the pending low half.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data <= '0;
            hold_id   <= '0;
        end else if (do_latch) begin
            hold_data <= dr_inttoint_d_out;
            hold_id   <= smc_id_in;
        end
    end

    // Queue storage. Accepted words occupy consecutive slots starting at the
    // write pointer; wrap-around comes from the pointer width.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (acc0) begin
                mem[wr_ptr] <= push0_e;
            end
            if (acc1) begin
                mem[wr_ptr + PW'(1)] <= push1_e;
            end
        end
    end

    // Queue pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(n_push) - CW'(pop);
            if ((push0_vld && !acc0) || (push1_vld && !acc1)) begin
                err_overflow <= 1'b1;
            end
        end
    end

    // Head presentation; the fields read as zero while the queue is empty.
    assign head    = mem[rd_ptr];
    assign wb_vld  = (count != '0);
    assign wb_data = wb_vld ? head.data : '0;
    assign wb_mask = wb_vld ? head.mask : '0;
    assign wb_id   = wb_vld ? head.id   : '0;

endmodule
